// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: binary-search controller that drives compare_n b and converges on its a input.
module sar_search_ctrl #(
  parameter int CMP_WIDTH = 4,
  parameter int STEP_W = $clog2(CMP_WIDTH + 2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 greater,
  input  logic                 equal,
  input  logic                 smaller,
  output logic [CMP_WIDTH-1:0] guess,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic                 error,
  output logic [CMP_WIDTH-1:0] result,
  output logic [STEP_W-1:0]    steps
);
  typedef enum logic {IDLE, PROBE} state_t;
  localparam logic [CMP_WIDTH-1:0] MAX = '1;
  state_t r_state, w_state_nx;
  logic [CMP_WIDTH-1:0] r_lo, r_hi, r_guess, r_result;
  logic [CMP_WIDTH-1:0] w_lo_nx, w_hi_nx, w_guess_nx, w_result_nx;
  logic [STEP_W-1:0] r_steps, w_steps_nx;
  logic r_busy, r_done, r_found, r_error;
  logic w_busy_nx, w_done_nx, w_found_nx, w_error_nx;
  logic w_legal, w_fin;
  logic [CMP_WIDTH:0] w_sum_up, w_sum_dn;
  // sums carry one extra bit so the midpoint never overflows
  assign w_sum_up = {1'b0, r_guess} + {1'b0, r_hi} + (CMP_WIDTH+1)'(1);
  assign w_sum_dn = {1'b0, r_lo} + {1'b0, r_guess} - (CMP_WIDTH+1)'(1);
  assign w_legal = $onehot({greater, equal, smaller});
  assign w_fin = !w_legal || equal || (greater && r_guess == MAX) || (smaller && r_guess == '0);
  always_comb begin
    w_state_nx = r_state;
    w_lo_nx = r_lo;
    w_hi_nx = r_hi;
    w_guess_nx = r_guess;
    w_result_nx = r_result;
    w_steps_nx = r_steps;
    w_busy_nx = r_busy;
    w_done_nx = 1'b0;
    w_found_nx = r_found;
    w_error_nx = r_error;
    if (r_state == IDLE) begin
      if (start) begin
        w_lo_nx = '0;
        w_hi_nx = MAX;
        w_guess_nx = MAX >> 1;
        w_steps_nx = '0;
        w_found_nx = 1'b0;
        w_error_nx = 1'b0;
        w_result_nx = '0;
        w_busy_nx = 1'b1;
        w_state_nx = PROBE;
      end
    end else begin
      w_steps_nx = r_steps + STEP_W'(1);
      if (w_fin) begin
        w_error_nx = !w_legal;
        w_found_nx = w_legal && equal;
        w_result_nx = r_guess;
        w_busy_nx = 1'b0;
        w_done_nx = 1'b1;
        w_state_nx = IDLE;
      end else if (greater) begin
        w_lo_nx = r_guess + CMP_WIDTH'(1);
        w_guess_nx = w_sum_up[CMP_WIDTH:1];
      end else begin
        w_hi_nx = r_guess - CMP_WIDTH'(1);
        w_guess_nx = w_sum_dn[CMP_WIDTH:1];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_lo <= '0;
      r_hi <= '0;
      r_guess <= '0;
      r_result <= '0;
      r_steps <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_found <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_lo <= w_lo_nx;
      r_hi <= w_hi_nx;
      r_guess <= w_guess_nx;
      r_result <= w_result_nx;
      r_steps <= w_steps_nx;
      r_busy <= w_busy_nx;
      r_done <= w_done_nx;
      r_found <= w_found_nx;
      r_error <= w_error_nx;
    end
  end
  assign guess = r_guess;
  assign busy = r_busy;
  assign done = r_done;
  assign found = r_found;
  assign error = r_error;
  assign result = r_result;
  assign steps = r_steps;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl: directed searches checked cycle by cycle against an integer binary-search model.
module tb_sar_search_ctrl;
  localparam int W = 4;
  localparam int SW = 3;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic greater, equal, smaller;
  logic [W-1:0] guess, result;
  logic [SW-1:0] steps;
  logic busy, done, found, error;
  int mode = 0, a_val = 0;
  int n_cmp = 0, n_bad = 0;
  int exp_q[$];
  int m_res, m_steps, m_found, m_err;
  sar_search_ctrl #(.CMP_WIDTH(W), .STEP_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .greater(greater), .equal(equal), .smaller(smaller),
    .guess(guess), .busy(busy), .done(done), .found(found),
    .error(error), .result(result), .steps(steps)
  );
  always #5 clk = ~clk;
  // comparator: 0 real compare, 1 always greater, 2 greater+smaller, 3 no flags
  always_comb begin
    greater = 1'b0;
    equal = 1'b0;
    smaller = 1'b0;
    case (mode)
      0: begin
        greater = a_val > int'(guess);
        equal = a_val == int'(guess);
        smaller = a_val < int'(guess);
      end
      1: greater = 1'b1;
      2: begin
        greater = 1'b1;
        smaller = 1'b1;
      end
      default: ;
    endcase
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model(input int m, input int a);
    int lo, hi, g, tgt;
    exp_q.delete();
    lo = 0;
    hi = (1 << W) - 1;
    g = hi / 2;
    tgt = (m == 1) ? (1 << W) : a;
    m_found = 0;
    m_err = 0;
    forever begin
      exp_q.push_back(g);
      if (m >= 2) begin
        m_err = 1;
        break;
      end
      if (tgt == g) begin
        m_found = 1;
        break;
      end
      if (tgt > g) begin
        if (g == (1 << W) - 1) break;
        lo = g + 1;
      end else begin
        if (g == 0) break;
        hi = g - 1;
      end
      g = (lo + hi) / 2;
    end
    m_res = g;
    m_steps = exp_q.size();
  endtask
  task automatic run(input int m, input int a, input bit again,
                     input int l_res, input int l_steps, input int l_found, input int l_err);
    mode = m;
    a_val = a;
    model(m, a);
    chk("model_result", m_res, l_res);
    chk("model_steps", m_steps, l_steps);
    chk("model_found", m_found, l_found);
    chk("model_error", m_err, l_err);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = again;
    for (int k = 0; k < m_steps; k++) begin
      chk("probe_guess", guess, exp_q[k]);
      chk("probe_busy", busy, 1);
      chk("probe_done", done, 0);
      @(negedge clk) start = 1'b0;
    end
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_found", found, m_found);
    chk("end_error", error, m_err);
    chk("end_result", result, m_res);
    chk("end_steps", steps, m_steps);
    chk("end_guess_hold", guess, m_res);
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_result_hold", result, m_res);
  endtask
  task automatic chk_zero(input string name);
    chk({name, "_guess"}, guess, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_found"}, found, 0);
    chk({name, "_error"}, error, 0);
    chk({name, "_result"}, result, 0);
    chk({name, "_steps"}, steps, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    model(0, 9);
    chk("model_seq_a9_p2", exp_q[1], 11);
    model(0, 0);
    chk("model_seq_a0_p2", exp_q[1], 3);
    run(0, 9, 1'b0, 9, 3, 1, 0);
    run(0, 15, 1'b0, 15, 5, 1, 0);
    run(0, 0, 1'b0, 0, 4, 1, 0);
    run(0, 6, 1'b0, 6, 4, 1, 0);
    run(1, 0, 1'b0, 15, 5, 0, 0);
    run(2, 0, 1'b0, 7, 1, 0, 1);
    run(3, 0, 1'b0, 7, 1, 0, 1);
    run(0, 9, 1'b1, 9, 3, 1, 0);
    mode = 0;
    a_val = 9;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midreset_no_done", done, 0);
      chk("midreset_idle", busy, 0);
    end
    run(0, 9, 1'b0, 9, 3, 1, 0);
    @(negedge clk) start = 1'b1;
    repeat (4) @(negedge clk);
    chk("held_done", done, 1);
    @(negedge clk);
    chk("held_restart_busy", busy, 1);
    chk("held_restart_guess", guess, 7);
    chk("held_restart_done", done, 0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_second_done", done, 1);
    chk("held_second_result", result, 9);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
